// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - round-robin arbiter and access sequencer for the shared data memory port
//
// Shares one data memory port among four requesters (0: CPU load/store,
// 1: instruction-fetch refill, 2: debug, 3: DMA). The winner's index drives
// the select of the external 4:1 address / write-data / write-enable muxes.
// The memory enable is held for MEM_LAT cycles. The winner then gets a
// one-cycle done pulse.
//
// Ports:
//   clk_i     system clock, rising edge
//   rst_i     asynchronous active-high reset
//   req_i     per-requester request, held until the matching done_o bit
//   we_i      per-requester write flag, sampled at grant only
//   select_o  binary index of the current or last winner (mux select)
//   gnt_o     one-hot grant, high for the whole access
//   mem_en_o  data memory enable
//   mem_we_o  data memory write enable (winner's we_i latched at grant)
//   done_o    one-hot one-cycle completion pulse
//   busy_o    high whenever the sequencer is not idle

module dmem_port_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] req_i,
    input  logic [3:0] we_i,
    output logic [1:0] select_o,
    output logic [3:0] gnt_o,
    output logic       mem_en_o,
    output logic       mem_we_o,
    output logic [3:0] done_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t     state;
    logic [1:0] ptr;
    logic [3:0] cnt;

    // Round-robin pick: first set request bit starting at ptr and wrapping.
    logic [1:0] winner;
    logic       found;
    logic [1:0] idx;

    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req_i[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            cnt      <= 4'd0;
            select_o <= 2'd0;
            gnt_o    <= 4'd0;
            mem_en_o <= 1'b0;
            mem_we_o <= 1'b0;
            done_o   <= 4'd0;
            busy_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // select_o is left alone when nothing is requested so the
                    // mux output does not move between accesses.
                    if (found) begin
                        select_o <= winner;
                        gnt_o    <= 4'b0001 << winner;
                        mem_en_o <= 1'b1;
                        mem_we_o <= we_i[winner];
                        busy_o   <= 1'b1;
                        cnt      <= CNT_INIT;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The access runs to completion even if the winner drops
                    // its request early; all inputs are ignored here.
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        gnt_o    <= 4'd0;
                        mem_en_o <= 1'b0;
                        mem_we_o <= 1'b0;
                        done_o   <= 4'b0001 << select_o;
                        ptr      <= select_o + 2'd1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    // One dead cycle so the winner can lower its request
                    // before the next arbitration.
                    done_o <= 4'd0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    gnt_o    <= 4'd0;
                    mem_en_o <= 1'b0;
                    mem_we_o <= 1'b0;
                    done_o   <= 4'd0;
                    busy_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Round-robin arbiter and access sequencer that shares the single-cycle CPU's data memory port among four requesters: CPU load/store, instruction-fetch refill, debug port and DMA. It drives the 2-bit select of the 4:1 data-memory multiplexers that steer address, write data and write-enable. It also holds the memory enable for a parameterized access latency and returns a one-cycle completion pulse to the winner. It sits between the requesters and the data memory, alongside the 4:1 muxes it controls.

## Interface
- MEM_LAT, 2, cycles the memory enable is held per access; legal range 1..15
- clk_i  in  1  system clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- req_i  in  4  request per requester; bit i held high until done_o[i] seen
- we_i  in  4  write flag per requester; sampled only at grant
- select_o  out  2  binary index of current or last winner; drives the 4:1 mux select_i
- gnt_o  out  4  one-hot grant, high for the whole access
- mem_en_o  out  1  data memory enable
- mem_we_o  out  1  data memory write enable (registered we_i of winner)
- done_o  out  4  one-hot, one-cycle completion pulse to winner
- busy_o  out  1  high whenever state is not IDLE

## Operation
- All outputs are registered. Reset values: select_o=0, gnt_o=0, mem_en_o=0, mem_we_o=0, done_o=0, busy_o=0. Internal state: FSM=IDLE, rotation pointer ptr=0, counter cnt=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, req_i==0: hold all outputs. select_o keeps its last value so the mux output stays stable.
- IDLE, req_i!=0: the winner w is the first set bit searched in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - At the clock edge: select_o<=w, gnt_o<=1<<w, mem_en_o<=1, mem_we_o<=we_i[w], busy_o<=1, cnt<=MEM_LAT-1. Go to ACCESS.
- ACCESS, cnt!=0: cnt<=cnt-1. All outputs hold.
- ACCESS, cnt==0: at the edge, gnt_o<=0, mem_en_o<=0, mem_we_o<=0, done_o<=1<<w, ptr<=(w+1) mod 4. Go to RESP.
- RESP: lasts exactly one cycle, and req_i is ignored during it. At the edge: done_o<=0, busy_o<=0. Go to IDLE.
- Requester rule: drop req_i[w] by the edge that ends the done_o cycle. The arbiter first samples req_i again in IDLE.
- req_i[w] dropped during ACCESS is a protocol violation. The access still completes and done_o still pulses.
- Changes on we_i or on non-winner req_i during ACCESS or RESP are ignored.
- ptr arithmetic is 2-bit and wraps naturally: w=3 gives ptr=0.
- rst_i asserted in any state forces reset values immediately, without waiting for a clock. It aborts any in-flight access, with no done_o pulse. After deassertion, arbitration restarts with ptr=0.

## Timing
- Request latency: req_i rises in cycle 0 while IDLE, giving:
  - gnt_o and mem_en_o high in cycles 1..MEM_LAT
  - done_o in cycle MEM_LAT+1
  - IDLE in cycle MEM_LAT+2, with a new grant visible in cycle MEM_LAT+3
- Throughput: back-to-back accesses issue every MEM_LAT+2 cycles.
- select_o changes only on the IDLE→ACCESS edge, so it never glitches mid-access.
- Invariants:
  - gnt_o and done_o are never both nonzero.
  - At most one bit of each is set.
  - mem_en_o==|gnt_o.

## Test plan
- Single request, MEM_LAT=2: req_i=0001 set at cycle 0 -> select_o=0, gnt_o=0001 and mem_en_o=1 in cycles 1-2; done_o=0001 in cycle 3; busy_o=0 in cycle 4.
- Fairness: req_i=1111 held, each requester re-raised after its done -> grant order 0,1,2,3,0,1; select_o sequence 0,1,2,3,0,1; never the same requester twice while others wait.
- Rotation/wrap: after granting requester 2, apply req_i=1011 -> grants to 3, then 0, then 1; ptr wraps 3→0.
- Write path: req_i=0100 with we_i=0100 -> mem_we_o=1 during access, select_o=2. Toggling we_i[2] to 0 mid-access leaves mem_we_o=1 until done.
- Async reset mid-ACCESS: with MEM_LAT=3, assert rst_i in cycle 2 between clock edges -> all outputs 0 immediately and no done_o pulse. Release, then req_i=0110 -> requester 1 is granted (ptr=0).
- MEM_LAT=1 corner: req_i=1000 -> gnt_o=1000 for exactly one cycle (cycle 1), done_o=1000 in cycle 2, next grant possible in cycle 4.
